// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bundle: instruction-memory request/reply, decode handshake and redirect.
interface instruction_fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    modport master (
        output imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
        input  imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready,
               redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
        output imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready,
               redirect_valid, redirect_pc
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: credit-limited word requests, in-order prefetch FIFO to decode,
// redirect flushes the FIFO and counts off replies still in flight as stale.
module instruction_fetch_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                      clk,
    input  logic                      reset,
    instruction_fetch_unit_if.master  bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned SW = CW + 1;

    logic          r_started;
    logic [31:0]   r_fetch_pc;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_drop_cnt;
    logic [CW-1:0] r_count;
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_pcq_wr;
    logic [PW-1:0] r_pcq_rd;
    logic [31:0]   r_pcq       [DEPTH];
    logic [31:0]   r_fifo_data [DEPTH];
    logic [31:0]   r_fifo_pc   [DEPTH];

    logic          w_credit;
    logic          w_req_valid;
    logic          w_inst_valid;
    logic          w_req_fire;
    logic          w_pop;
    logic          w_drop;
    logic          w_push;
    logic [CW-1:0] w_out_next;
    logic          w_unused;

    // Requests are gated until the first edge after reset so the reset state shows no request.
    assign w_credit     = ({1'b0, r_outstanding} + {1'b0, r_count}) < SW'(DEPTH);
    assign w_req_valid  = r_started && !bus.redirect_valid && w_credit;
    assign w_inst_valid = (r_count != '0) && !bus.redirect_valid;
    assign w_req_fire   = w_req_valid && bus.imem_req_ready;
    assign w_pop        = w_inst_valid && bus.inst_ready;
    assign w_drop       = bus.imem_resp_valid && (bus.redirect_valid || (r_drop_cnt != '0));
    assign w_push       = bus.imem_resp_valid && !w_drop;
    assign w_out_next   = r_outstanding + CW'(w_req_fire) - CW'(bus.imem_resp_valid);
    assign w_unused     = ^bus.redirect_pc[1:0];

    assign bus.imem_req_valid = w_req_valid;
    assign bus.imem_req_addr  = r_fetch_pc;
    assign bus.inst_valid     = w_inst_valid;
    assign bus.inst_data      = r_fifo_data[r_rd_ptr];
    assign bus.inst_pc        = r_fifo_pc[r_rd_ptr];

    // Fetch PC, in-flight accounting and stale-reply counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_started     <= 1'b0;
            r_fetch_pc    <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
            r_pcq_wr      <= '0;
            r_pcq_rd      <= '0;
        end else begin
            r_started     <= 1'b1;
            r_outstanding <= w_out_next;
            if (bus.redirect_valid)
                r_fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
            else if (w_req_fire)
                r_fetch_pc <= r_fetch_pc + 32'd4;
            if (bus.redirect_valid)
                r_drop_cnt <= w_out_next;
            else if (bus.imem_resp_valid && (r_drop_cnt != '0))
                r_drop_cnt <= r_drop_cnt - CW'(1);
            if (w_req_fire)
                r_pcq_wr <= r_pcq_wr + PW'(1);
            if (bus.imem_resp_valid)
                r_pcq_rd <= r_pcq_rd + PW'(1);
        end
    end

    // PC of every issued request, consumed in reply order whether kept or dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) r_pcq[i] <= '0;
        end else if (w_req_fire) begin
            r_pcq[r_pcq_wr] <= r_fetch_pc;
        end
    end

    // Prefetch FIFO; a redirect empties it in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_fifo_data[i] <= '0;
                r_fifo_pc[i]   <= '0;
            end
        end else if (bus.redirect_valid) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_fifo_data[r_wr_ptr] <= bus.imem_resp_data;
                r_fifo_pc[r_wr_ptr]   <= r_pcq[r_pcq_rd];
                r_wr_ptr              <= r_wr_ptr + PW'(1);
            end
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Randomized bench for instruction_fetch_unit: memory responder plus a stream-level
// model (expected fetch addresses, buffered fresh PCs, epochs for stale replies).
module tb_instruction_fetch_unit;
    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    instruction_fetch_unit_if bif();

    instruction_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif.master)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
        int          epoch;
    } req_t;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    req_t        memq[$];
    logic [31:0] m_buf[$];
    logic [31:0] m_fetch = RESET_PC;
    int          m_epoch = 0;
    bit          m_started = 1'b0;
    int          last_due = 0;
    int          n_drop = 0;
    int          n_acc = 0;
    logic [31:0] pop_log[$];
    int          pop_cyc[$];
    logic [31:0] acc_log[$];
    int          lat_min = 1, lat_max = 1, p_rr = 100, p_ir = 100, p_rd = 0;
    int          rel_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h1234_5678;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h cyc=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic pin_log(input string name, input int idx, input logic [31:0] exp);
        if (idx >= pop_log.size()) begin
            checks++;
            failures++;
            $display("FAIL %s actual=none required=%h", name, exp);
        end else begin
            check32(name, pop_log[idx], exp);
        end
    endtask

    // Compare process: outputs against the model, then commit this cycle's handshakes.
    always @(negedge clk) begin : chk
        bit   ev_req;
        bit   ev_inst;
        req_t e;
        int   due;
        if (!reset) begin
            memq.delete();
            m_buf.delete();
            m_fetch   = RESET_PC;
            m_started = 1'b0;
            last_due  = 0;
            check32("rst_req_valid",  32'(bif.imem_req_valid), 32'd0);
            check32("rst_inst_valid", 32'(bif.inst_valid), 32'd0);
            check32("rst_req_addr",   bif.imem_req_addr, RESET_PC);
            check32("rst_inst_data",  bif.inst_data, 32'd0);
            check32("rst_inst_pc",    bif.inst_pc, 32'd0);
        end else begin
            ev_req  = m_started && !bif.redirect_valid && (memq.size() + m_buf.size() < DEPTH);
            ev_inst = (m_buf.size() != 0) && !bif.redirect_valid;
            check32("req_valid", 32'(bif.imem_req_valid), 32'(ev_req));
            if (ev_req) check32("req_addr", bif.imem_req_addr, m_fetch);
            check32("inst_valid", 32'(bif.inst_valid), 32'(ev_inst));
            if (ev_inst) begin
                check32("inst_pc", bif.inst_pc, m_buf[0]);
                check32("inst_data", bif.inst_data, mem_word(m_buf[0]));
            end
            if (ev_inst && bif.inst_ready) begin
                pop_log.push_back(bif.inst_pc);
                pop_cyc.push_back(cyc);
                void'(m_buf.pop_front());
            end
            if (bif.imem_resp_valid && memq.size() != 0) begin
                e = memq.pop_front();
                if (!bif.redirect_valid && e.epoch == m_epoch) m_buf.push_back(e.addr);
                else n_drop++;
            end
            if (ev_req && bif.imem_req_ready) begin
                due = cyc + int'($urandom_range(lat_max, lat_min));
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                memq.push_back('{m_fetch, due, m_epoch});
                acc_log.push_back(bif.imem_req_addr);
                m_fetch = m_fetch + 32'd4;
                n_acc++;
            end
            if (bif.redirect_valid) begin
                m_buf.delete();
                m_epoch++;
                m_fetch = {bif.redirect_pc[31:2], 2'b00};
            end
            m_started = 1'b1;
        end
    end

    // One cycle of stimulus: memory reply from the queue head, random handshake inputs.
    task automatic step();
        @(posedge clk);
        #1;
        if (reset && memq.size() != 0 && memq[0].due == cyc) begin
            bif.imem_resp_valid = 1'b1;
            bif.imem_resp_data  = mem_word(memq[0].addr);
        end else begin
            bif.imem_resp_valid = 1'b0;
            bif.imem_resp_data  = $urandom;
        end
        bif.imem_req_ready = ($urandom_range(99, 0) < p_rr);
        bif.inst_ready     = ($urandom_range(99, 0) < p_ir);
        if (!bif.redirect_valid && reset && ($urandom_range(99, 0) < p_rd)) begin
            bif.redirect_valid = 1'b1;
            bif.redirect_pc    = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0)))
                                                              : $urandom;
        end else begin
            bif.redirect_valid = 1'b0;
            bif.redirect_pc    = $urandom;
        end
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        reset = 1'b0;
        bif.redirect_valid  = 1'b0;
        bif.imem_resp_valid = 1'b0;
        step();
        step();
        reset   = 1'b1;
        rel_cyc = cyc;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int log0, acc0, drop0, a0, k;
        bif.imem_req_ready  = 1'b0;
        bif.imem_resp_valid = 1'b0;
        bif.imem_resp_data  = '0;
        bif.inst_ready      = 1'b0;
        bif.redirect_valid  = 1'b0;
        bif.redirect_pc     = '0;

        // Back-to-back delivery with one-cycle memory.
        do_reset();
        log0 = pop_log.size();
        run(12);
        for (int i = 0; i < 4; i++) begin
            pin_log("t1_pc", log0 + i, 32'(4 * i));
            if (log0 + i < pop_cyc.size())
                check32("t1_cycle", 32'(pop_cyc[log0 + i] - rel_cyc), 32'(3 + i));
        end

        // Decode stalled: credit caps the requests at DEPTH.
        p_ir = 0;
        do_reset();
        acc0 = n_acc;
        run(20);
        check32("t2_accepts", 32'(n_acc - acc0), 32'(DEPTH));
        check32("t2_req_valid", 32'(bif.imem_req_valid), 32'd0);
        check32("t2_req_addr", bif.imem_req_addr, 32'h10);
        p_ir = 100;
        bif.inst_ready = 1'b1;
        log0 = pop_log.size();
        run(10);
        for (int i = 0; i < 5; i++) pin_log("t2_pc", log0 + i, 32'(4 * i));

        // Redirect with three requests in flight at latency 3.
        lat_min = 3; lat_max = 3;
        do_reset();
        k = 0;
        while (memq.size() < 3 && k < 20) begin step(); k++; end
        check32("t3_wait", 32'(memq.size()), 32'd3);
        bif.redirect_valid = 1'b1;
        bif.redirect_pc    = 32'h100;
        drop0 = n_drop;
        log0  = pop_log.size();
        run(20);
        check32("t3_drops", 32'(n_drop - drop0), 32'd3);
        pin_log("t3_pc", log0, 32'h100);

        // Redirect coincident with a reply while decode is ready.
        lat_min = 1; lat_max = 1;
        k = 0;
        while (!(bif.imem_resp_valid && m_buf.size() != 0) && k < 50) begin step(); k++; end
        check32("t4_wait", 32'(bif.imem_resp_valid && m_buf.size() != 0), 32'd1);
        bif.redirect_valid = 1'b1;
        bif.redirect_pc    = 32'h203;
        #1;
        check32("t4_inst_valid", 32'(bif.inst_valid), 32'd0);
        log0 = pop_log.size();
        run(10);
        pin_log("t4_pc", log0, 32'h200);

        // Address wrap under random request stalls.
        p_rr = 50;
        step();
        bif.redirect_valid = 1'b1;
        bif.redirect_pc    = 32'hFFFF_FFF8;
        a0 = acc_log.size();
        run(40);
        if (acc_log.size() < a0 + 3) begin
            checks++; failures++;
            $display("FAIL t5_accepts actual=%0d required=3", acc_log.size() - a0);
        end else begin
            check32("t5_addr0", acc_log[a0],     32'hFFFF_FFF8);
            check32("t5_addr1", acc_log[a0 + 1], 32'hFFFF_FFFC);
            check32("t5_addr2", acc_log[a0 + 2], 32'h0000_0000);
        end

        // Random traffic: latency, stalls, decode backpressure and redirects.
        lat_min = 1; lat_max = 4; p_rr = 70; p_ir = 70; p_rd = 3;
        run(3000);

        // Reset asserted with three words buffered.
        p_rd = 0; p_ir = 0; p_rr = 100; lat_min = 1; lat_max = 1;
        bif.inst_ready = 1'b0;
        k = 0;
        while (m_buf.size() != 3 && k < 100) begin step(); k++; end
        check32("t6_wait", 32'(m_buf.size()), 32'd3);
        #1;
        reset = 1'b0;
        #1;
        check32("t6_req_valid",  32'(bif.imem_req_valid), 32'd0);
        check32("t6_inst_valid", 32'(bif.inst_valid), 32'd0);
        check32("t6_req_addr",   bif.imem_req_addr, RESET_PC);
        check32("t6_inst_data",  bif.inst_data, 32'd0);
        check32("t6_inst_pc",    bif.inst_pc, 32'd0);
        bif.redirect_valid  = 1'b0;
        bif.imem_resp_valid = 1'b0;
        step();
        step();
        reset = 1'b1;
        p_ir = 100;
        bif.inst_ready = 1'b1;
        log0 = pop_log.size();
        run(10);
        pin_log("t6_pc", log0, RESET_PC);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
